// File: rtl/arb_pkg.sv
// Shared types, decode field positions and credit arithmetic for the credit bus arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int DEC_BASE_LSB = 16;
    localparam int DEC_SLV_LSB  = 12;
    localparam int DEC_SLV_W    = 4;

    // Deduct first and floor at zero, then add the refill and clip at the ceiling.
    function automatic int sat_add_sub(input int credit, input int cost, input int amt, input int cmax);
        int tmp;
        tmp = (credit > cost) ? (credit - cost) : 0;
        tmp = tmp + amt;
        if (tmp > cmax) begin
            tmp = cmax;
        end
        return tmp;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select: starvation first, then highest priority among
// credited requesters (or all requesters when none has credit), RR tie-break.
module arb_pick #(
    parameter int NUM_MST = 4,
    parameter int PRI_W   = 4,
    localparam int IW     = $clog2(NUM_MST)
) (
    input  logic [NUM_MST-1:0]       req,
    input  logic [NUM_MST*PRI_W-1:0] pri,
    input  logic [NUM_MST-1:0]       cred_nz,
    input  logic [NUM_MST-1:0]       starved,
    input  logic [NUM_MST-1:0]       exclude,
    input  logic [IW-1:0]            rr_ptr,
    output logic                     valid,
    output logic [IW-1:0]            winner
);

    logic [NUM_MST-1:0] elig;
    logic [NUM_MST-1:0] starve_set;
    logic [NUM_MST-1:0] pool;
    logic [PRI_W-1:0]   best_pri;
    logic               found;
    int                 idx;

    always_comb begin
        elig       = req & ~exclude;
        starve_set = elig & starved;
        pool       = ((elig & cred_nz) != '0) ? (elig & cred_nz) : elig;
        valid      = (elig != '0);
        winner     = '0;
        best_pri   = '0;
        found      = 1'b0;
        idx        = 0;
        if (starve_set != '0) begin
            for (int i = NUM_MST - 1; i >= 0; i--) begin
                if (starve_set[i]) begin
                    winner = IW'(i);
                end
            end
        end else begin
            // Walking from the RR pointer with a strict '>' keeps the first tied master.
            for (int k = 0; k < NUM_MST; k++) begin
                idx = (int'(rr_ptr) + k) % NUM_MST;
                if (pool[idx] && (!found || (pri[idx*PRI_W +: PRI_W] > best_pri))) begin
                    found    = 1'b1;
                    best_pri = pri[idx*PRI_W +: PRI_W];
                    winner   = IW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/credit_bus_arbiter.sv
// N-master / M-slave shared-bus arbiter with per-master credit buckets,
// starvation override, hold limit and address-decoded slave routing.
//   state | meaning
//   IDLE  | no owner; bus outputs parked at zero, arbitrate every cycle
//   OWN   | owner_id holds the bus until it drops m_req or hits the hold limit
module credit_bus_arbiter
    import arb_pkg::*;
#(
    parameter int          NUM_MST       = 4,
    parameter int          NUM_SLV       = 4,
    parameter int          DW            = 32,
    parameter int          PRI_W         = 4,
    parameter int          CRED_W        = 8,
    parameter int          CRED_INIT     = 16,
    parameter int          REFILL_AMT    = 4,
    parameter int          REFILL_PERIOD = 10,
    parameter int          CRED_MAX      = 64,
    parameter int          STARVE_LIM    = 59,
    parameter int          HOLD_MAX      = 16,
    parameter logic [15:0] BASE_HI       = 16'hFFEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_MST-1:0]         m_req,
    input  logic [NUM_MST*PRI_W-1:0]   m_pri,
    input  logic [NUM_MST*32-1:0]      m_addr,
    input  logic [NUM_MST-1:0]         m_rw,
    input  logic [NUM_MST*DW-1:0]      m_wdata,
    output logic [NUM_MST-1:0]         m_grant,
    output logic [DW-1:0]              m_rdata,
    output logic [NUM_SLV-1:0]         s_sel,
    output logic [31:0]                s_addr,
    output logic                       s_rw,
    output logic [DW-1:0]              s_wdata,
    input  logic [NUM_SLV*DW-1:0]      s_rdata,
    output logic                       dec_err,
    output logic [$clog2(NUM_MST)-1:0] owner_id
);

    localparam int IW = $clog2(NUM_MST);
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam int RW = $clog2(REFILL_PERIOD + 1);
    localparam int TW = $clog2(STARVE_LIM + 1);

    arb_state_e         state_q, state_d;
    logic [NUM_MST-1:0] grant_q;
    logic [IW-1:0]      owner_q;
    logic [HW-1:0]      hold_q;
    logic [IW-1:0]      rr_q;
    logic [RW-1:0]      refill_q;
    logic [CRED_W-1:0]  credit_q [NUM_MST];
    logic [CRED_W-1:0]  credit_d [NUM_MST];
    logic [TW-1:0]      timer_q  [NUM_MST];
    logic [TW-1:0]      timer_d  [NUM_MST];

    logic               hold_end;
    logic               rel;
    logic               arb_go;
    logic               grant_take;
    logic               refill_tc;
    logic [NUM_MST-1:0] excl;
    logic [NUM_MST-1:0] cred_nz;
    logic [NUM_MST-1:0] starved;
    logic               pick_valid;
    logic [IW-1:0]      pick_idx;

    assign hold_end   = (state_q == OWN) && (hold_q == HW'(HOLD_MAX - 1));
    assign rel        = (state_q == OWN) && (!m_req[owner_q] || hold_end);
    assign arb_go     = (state_q == IDLE) || rel;
    assign grant_take = arb_go && pick_valid;
    assign refill_tc  = (refill_q == RW'(REFILL_PERIOD - 1));
    // A hold-limited owner sits out the arbitration it triggered.
    assign excl       = hold_end ? (NUM_MST'(1) << owner_q) : '0;

    always_comb begin
        for (int i = 0; i < NUM_MST; i++) begin
            cred_nz[i] = (credit_q[i] != '0);
            starved[i] = (timer_q[i] == TW'(STARVE_LIM));
        end
    end

    arb_pick #(
        .NUM_MST (NUM_MST),
        .PRI_W   (PRI_W)
    ) u_pick (
        .req     (m_req),
        .pri     (m_pri),
        .cred_nz (cred_nz),
        .starved (starved),
        .exclude (excl),
        .rr_ptr  (rr_q),
        .valid   (pick_valid),
        .winner  (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        if (arb_go) begin
            state_d = pick_valid ? OWN : IDLE;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_MST; i++) begin
            credit_d[i] = CRED_W'(sat_add_sub(
                int'(credit_q[i]),
                (grant_take && (pick_idx == IW'(i))) ? (int'(m_pri[i*PRI_W +: PRI_W]) + 1) : 0,
                refill_tc ? REFILL_AMT : 0,
                CRED_MAX));
            if (!m_req[i] || grant_q[i]) begin
                timer_d[i] = '0;
            end else if (timer_q[i] != TW'(STARVE_LIM)) begin
                timer_d[i] = timer_q[i] + 1'b1;
            end else begin
                timer_d[i] = timer_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            hold_q   <= '0;
            rr_q     <= '0;
            refill_q <= '0;
            for (int i = 0; i < NUM_MST; i++) begin
                credit_q[i] <= CRED_W'(CRED_INIT);
                timer_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            refill_q <= refill_tc ? '0 : (refill_q + 1'b1);
            for (int i = 0; i < NUM_MST; i++) begin
                credit_q[i] <= credit_d[i];
                timer_q[i]  <= timer_d[i];
            end
            if (arb_go) begin
                grant_q <= pick_valid ? (NUM_MST'(1) << pick_idx) : '0;
            end
            if (grant_take) begin
                owner_q <= pick_idx;
                hold_q  <= '0;
                rr_q    <= (int'(pick_idx) == NUM_MST - 1) ? '0 : (pick_idx + 1'b1);
            end else if (state_q == OWN) begin
                hold_q  <= hold_q + 1'b1;
            end
        end
    end

    assign m_grant  = grant_q;
    assign owner_id = owner_q;

    logic [31:0]          own_addr;
    logic [DEC_SLV_W-1:0] slv_idx;

    always_comb begin
        s_sel    = '0;
        dec_err  = 1'b0;
        m_rdata  = '0;
        s_addr   = '0;
        s_rw     = 1'b0;
        s_wdata  = '0;
        own_addr = m_addr[owner_q*32 +: 32];
        slv_idx  = own_addr[DEC_SLV_LSB +: DEC_SLV_W];
        if (state_q == OWN) begin
            s_addr  = own_addr;
            s_rw    = m_rw[owner_q];
            s_wdata = m_wdata[owner_q*DW +: DW];
            if ((own_addr[31:DEC_BASE_LSB] == BASE_HI) && (int'(slv_idx) < NUM_SLV)) begin
                s_sel   = NUM_SLV'(1) << slv_idx;
                m_rdata = s_rdata[slv_idx*DW +: DW];
            end else begin
                dec_err = 1'b1;
            end
        end
    end

endmodule

// File: doc/credit_bus_arbiter.md
Name: credit_bus_arbiter

Overview:
- Parametrised N-master / M-slave shared-bus arbiter.
- Each master owns a credit bucket that refills periodically. Arbitration is priority-weighted, with starvation override, round-robin tie-break and a maximum-hold limit.
- Address decode routes the granted master's address, write data and RW to one slave. Read data returns from that slave.
- Sits between the bmif master ports and svif slave ports, replacing the fixed 4x4 arbiter.

Parameters:
NUM_MST, 4, number of masters (2..8)
NUM_SLV, 4, number of slaves (1..16)
DW, 32, data width
PRI_W, 4, per-master priority/cost width
CRED_W, 8, credit counter width
CRED_INIT, 16, credit value loaded at reset
REFILL_AMT, 4, credits added per refill event
REFILL_PERIOD, 10, cycles between refill events (>=1)
CRED_MAX, 64, credit saturation ceiling (<= 2^CRED_W-1)
STARVE_LIM, 59, waiting cycles that force a grant
HOLD_MAX, 16, maximum consecutive grant cycles
BASE_HI, 16'hFFEF, required addr[31:16] for a valid decode

Ports:
clk  in  1  bus clock, rising edge
rst  in  1  asynchronous reset, active-low
m_req  in  NUM_MST  per-master transfer request (xfr)
m_pri  in  NUM_MST*PRI_W  per-master priority, also the credit cost
m_addr  in  NUM_MST*32  per-master address
m_rw  in  NUM_MST  per-master read/write
m_wdata  in  NUM_MST*DW  per-master write data
m_grant  out  NUM_MST  one-hot grant, registered
m_rdata  out  DW  read data from the selected slave, valid for the granted master
s_sel  out  NUM_SLV  one-hot slave select
s_addr  out  32  granted master address
s_rw  out  1  granted master RW
s_wdata  out  DW  granted master write data
s_rdata  in  NUM_SLV*DW  per-slave read data
dec_err  out  1  granted address fails decode
owner_id  out  $clog2(NUM_MST)  index of the current owner

Behaviour:
Reset (rst low, asynchronous):
- m_grant=0, owner_id=0, state IDLE.
- All credits = CRED_INIT; all starvation timers = 0.
- Round-robin pointer = 0; refill counter = 0; hold counter = 0.

Data path (combinational from registered owner):
- When state IDLE: s_sel=0, dec_err=0, m_rdata=0, s_addr/s_rw/s_wdata=0.

State machine (states IDLE, OWN):
- An arbitration cycle occurs when state is IDLE, or state is OWN and the owner releases.
- Owner releases when m_req[owner]=0 or hold_cnt = HOLD_MAX-1.
- On a forced (hold) release, the old owner is excluded from that arbitration cycle.
- Winner found: next state OWN, m_grant/owner_id update at the next edge. Grant latency is 1 cycle, and back-to-back ownership changes are allowed.
- No winner: next state IDLE.
- hold_cnt clears on each new grant and increments while in OWN.

Winner selection (precedence, highest first):
1. Any requester with timer = STARVE_LIM; lowest index among them.
2. Among requesters with credit > 0: highest m_pri. Ties go to the first index at or after the RR pointer.
3. If no requester has credit: same rule applied across all requesters (work-conserving).
- RR pointer = winner+1 mod NUM_MST on each grant.

Credits (CRED_W unsigned):
- On grant, the winner's credit is reduced by m_pri+1, floored at 0.
- Refill counter counts 0..REFILL_PERIOD-1. At terminal count, every credit gains REFILL_AMT, saturating at CRED_MAX.
- If deduction and refill hit the same credit in the same cycle, deduct and floor first, then add and saturate.

Starvation timer, per master:
- Requesting and not granted this cycle: +1, saturating at STARVE_LIM.
- Granted, or m_req=0: cleared.

Decode (granted master only):
- addr[31:16]=BASE_HI and addr[15:12] < NUM_SLV: s_sel one-hot at addr[15:12], m_rdata = that slave's s_rdata.
- Otherwise: s_sel=0, dec_err=1, m_rdata=0. The grant is still held.

Other:
- A request withdrawn in the same cycle as its grant edge still produces one grant cycle, followed by release.

Decomposition:
- Package arb_pkg: state enum (IDLE, OWN), decode field positions, and the function sat_add_sub(credit, cost, amt, max).
- Sub-module arb_pick: combinational winner select from req, pri, credit-nonzero, starved, exclude mask and RR pointer; outputs valid and winner index.

Test Plan:
- Reset then m_req=4'b0011, pri0=2, pri1=5 -> m_grant=4'b0010 one cycle later; credit1 = 16-6 = 10.
- Equal pri=3 on all four masters, each dropping m_req after 1 cycle -> grants rotate 0,1,2,3,0 with no idle cycle between.
- m0 pri=15 requests continuously, m1 pri=1 requests continuously -> m0 is forced to release after 16 cycles and m1 is granted; m1 is granted no later than when its timer reaches 59.
- Credit drain: m0 credit reaches 0, m1 credit > 0 with lower pri -> m1 wins. Refill at cycle 10 adds 4, saturating at 64 after long idle.
- Granted m2 with addr=32'hFFEF3220, RW=1 -> s_sel=4'b1000, s_addr matches. addr=32'h12340000 -> s_sel=0, dec_err=1.
- rst low mid-OWN -> m_grant=0 and s_sel=0 immediately; credits read 16 after release.
